// File: rtl/dco_nco_multi_pkg.sv
// Shared constants and types for the multi-channel phase-accumulator NCO.
package dco_pkg;

    localparam int DEF_CH     = 2;
    localparam int DEF_CODE_W = 8;

    // Width of a channel index; a single channel still gets one index bit.
    function automatic int ch_idx_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    localparam int CH_IDX_W = ch_idx_w(DEF_CH);

    // Every channel comes out of reset running at the slowest nonzero rate.
    localparam int RST_CODE = 1;

    typedef logic [DEF_CODE_W-1:0] dco_code_t;

endpackage

// File: rtl/dco_nco_multi_channel.sv
// One NCO channel: phase accumulator plus a shadow code register. A written code
// waits in the shadow and is applied only at a period boundary (carry), while the
// channel is stopped, or while the active code is 0, so the output never glitches.
module dco_nco_channel import dco_pkg::*; #(
    parameter int CODE_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena_i,
    input  logic              ch_en_i,
    input  logic              wr_en_i,
    input  logic [CODE_W-1:0] wr_code_i,
    output logic              dco_o,
    output logic              wrap_o,
    output logic              pending_o
);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CODE_W-1:0] shadow_q, shadow_d;
    logic              pending_q, pending_d;
    logic              dco_q, dco_d;
    logic              wrap_q, wrap_d;

    logic [ACC_W:0]    sum;
    logic              carry;
    logic              apply;

    assign sum   = {1'b0, acc_q} + {{(ACC_W + 1 - CODE_W){1'b0}}, code_q};
    assign carry = sum[ACC_W];
    // A code accepted this cycle is not yet pending, so it cannot ride this carry.
    assign apply = pending_q & (carry | ~ch_en_i | (code_q == '0));

    // Next state: accumulate or clear, then code apply, then shadow capture.
    always_comb begin
        acc_d     = acc_q;
        code_d    = code_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        dco_d     = dco_q;
        wrap_d    = wrap_q;
        if (ena_i) begin
            if (ch_en_i) begin
                acc_d  = sum[ACC_W-1:0];
                wrap_d = carry;
                dco_d  = sum[ACC_W-1];
            end else begin
                acc_d  = '0;
                wrap_d = 1'b0;
                dco_d  = 1'b0;
            end
            if (apply) begin
                code_d    = shadow_q;
                pending_d = 1'b0;
            end
            if (wr_en_i) begin
                shadow_d  = wr_code_i;
                pending_d = 1'b1;
            end
        end
    end

    // State registers; reset drops any pending update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            code_q    <= CODE_W'(RST_CODE);
            shadow_q  <= '0;
            pending_q <= 1'b0;
            dco_q     <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            code_q    <= code_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            dco_q     <= dco_d;
            wrap_q    <= wrap_d;
        end
    end

    assign dco_o     = dco_q;
    assign wrap_o    = wrap_q;
    assign pending_o = pending_q;

endmodule

// File: rtl/dco_nco_multi.sv
// Multi-channel NCO top: code-update handshake decode, CH channel instances and an
// optional wrap-rate measurement (enabled by defining DCO_FREQ_MEAS_EN).
// Handshake: a code transfers on a cycle with ena & cfg_valid & cfg_ready; cfg_ready is
// combinational, low only while the addressed in-range channel still holds an unapplied
// code; writes to channel indices >= CH are accepted and dropped.
module dco_nco_multi import dco_pkg::*; #(
    parameter int CH     = 2,
    parameter int CODE_W = 8,
    parameter int ACC_W  = 16,
    parameter int MEAS_W = 12,
    localparam int CH_IDX_W = ch_idx_w(CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [CH-1:0]       ch_en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [CODE_W-1:0]   cfg_code,
    output logic [CH-1:0]       dco_out,
    output logic [CH-1:0]       wrap_pulse,
    input  logic [CH_IDX_W-1:0] meas_sel,
    output logic [MEAS_W:0]     meas_count,
    output logic                meas_valid
);

    localparam int                CH_SPAN = 1 << CH_IDX_W;
    localparam logic [CH_IDX_W:0] CH_NUM  = (CH_IDX_W + 1)'(CH);

    logic [CH-1:0]      pending;
    logic [CH_SPAN-1:0] pend_ext;
    logic               cfg_in_range;
    logic               accept;

    // Pad the pending vector to the full index range so any cfg_ch is a legal index.
    always_comb begin
        pend_ext         = '0;
        pend_ext[CH-1:0] = pending;
    end

    assign cfg_in_range = ({1'b0, cfg_ch} < CH_NUM);
    assign cfg_ready    = cfg_in_range ? ~pend_ext[cfg_ch] : 1'b1;
    assign accept       = ena & cfg_valid & cfg_ready & cfg_in_range;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        dco_nco_channel #(
            .CODE_W (CODE_W),
            .ACC_W  (ACC_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .ena_i     (ena),
            .ch_en_i   (ch_en[g]),
            .wr_en_i   (accept & (cfg_ch == CH_IDX_W'(g))),
            .wr_code_i (cfg_code),
            .dco_o     (dco_out[g]),
            .wrap_o    (wrap_pulse[g]),
            .pending_o (pending[g])
        );
    end

`ifdef DCO_FREQ_MEAS_EN
    logic [MEAS_W-1:0]  win_q, win_d;
    logic [MEAS_W:0]    wcnt_q, wcnt_d;
    logic [MEAS_W:0]    mcount_q, mcount_d;
    logic               mvalid_q, mvalid_d;
    logic [CH_SPAN-1:0] wrap_ext;
    logic               sel_wrap;

    // Pad the wrap vector so an out-of-range selection simply reads as no wraps.
    always_comb begin
        wrap_ext         = '0;
        wrap_ext[CH-1:0] = wrap_pulse;
    end

    assign sel_wrap = wrap_ext[meas_sel];

    // Window bookkeeping: the last window cycle publishes the count including its own wrap.
    always_comb begin
        win_d    = win_q;
        wcnt_d   = wcnt_q;
        mcount_d = mcount_q;
        mvalid_d = mvalid_q;
        if (ena) begin
            if (win_q == '1) begin
                mcount_d = wcnt_q + (MEAS_W + 1)'(sel_wrap);
                mvalid_d = 1'b1;
                wcnt_d   = '0;
                win_d    = '0;
            end else begin
                wcnt_d   = wcnt_q + (MEAS_W + 1)'(sel_wrap);
                win_d    = win_q + 1'b1;
                mvalid_d = 1'b0;
            end
        end
    end

    // Measurement registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q    <= '0;
            wcnt_q   <= '0;
            mcount_q <= '0;
            mvalid_q <= 1'b0;
        end else begin
            win_q    <= win_d;
            wcnt_q   <= wcnt_d;
            mcount_q <= mcount_d;
            mvalid_q <= mvalid_d;
        end
    end

    assign meas_count = mcount_q;
    assign meas_valid = mvalid_q;
`else
    logic unused_meas_sel;
    assign unused_meas_sel = ^meas_sel;
    assign meas_count      = '0;
    assign meas_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_dco_nco_multi.sv
// Bench for dco_nco_multi (ACC_W=8, CH=2, MEAS_W=10): behavioural model compared every
// cycle, directed period checks with literal expectations, and a randomized phase.
module tb_dco_nco_multi;
    import dco_pkg::*;

    localparam int CH     = 2;
    localparam int CODE_W = 8;
    localparam int ACC_W  = 8;
    localparam int MEAS_W = 10;
    localparam int IW     = ch_idx_w(CH);
    localparam int MOD    = 1 << ACC_W;
    localparam int HALF   = 1 << (ACC_W - 1);
    localparam int WIN    = 1 << MEAS_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              ena = 1'b0;
    logic [CH-1:0]     ch_en = '0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [IW-1:0]     cfg_ch = '0;
    logic [CODE_W-1:0] cfg_code = '0;
    logic [CH-1:0]     dco_out;
    logic [CH-1:0]     wrap_pulse;
    logic [IW-1:0]     meas_sel = '0;
    logic [MEAS_W:0]   meas_count;
    logic              meas_valid;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Clock / reset
    always #5 clk = ~clk;

    dco_nco_multi #(
        .CH     (CH),
        .CODE_W (CODE_W),
        .ACC_W  (ACC_W),
        .MEAS_W (MEAS_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .ch_en      (ch_en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_code   (cfg_code),
        .dco_out    (dco_out),
        .wrap_pulse (wrap_pulse),
        .meas_sel   (meas_sel),
        .meas_count (meas_count),
        .meas_valid (meas_valid)
    );

    // Behavioural model: phase as an integer modulo 2^ACC_W, per-channel code bookkeeping.
    int m_acc[CH], m_code[CH], m_sh[CH], m_pend[CH], m_dco[CH], m_wrap[CH];
    int m_win, m_wcnt, m_mcount, m_mvalid;
    int md_s, md_sel_w;
    bit md_carry, md_take;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                m_acc[i] = 0; m_code[i] = 1; m_sh[i] = 0; m_pend[i] = 0;
                m_dco[i] = 0; m_wrap[i] = 0;
            end
            m_win = 0; m_wcnt = 0; m_mcount = 0; m_mvalid = 0;
        end else if (ena) begin
            md_take  = cfg_valid && (int'(cfg_ch) < CH) && (m_pend[cfg_ch] == 0);
            md_sel_w = (int'(meas_sel) < CH) ? m_wrap[meas_sel] : 0;
            for (int i = 0; i < CH; i++) begin
                md_carry = 1'b0;
                if (ch_en[i]) begin
                    md_s     = m_acc[i] + m_code[i];
                    md_carry = (md_s >= MOD);
                    m_acc[i] = md_s % MOD;
                    m_wrap[i] = md_carry;
                    m_dco[i] = (m_acc[i] >= HALF);
                end else begin
                    m_acc[i] = 0; m_wrap[i] = 0; m_dco[i] = 0;
                end
                if (m_pend[i] != 0 && (md_carry || !ch_en[i] || m_code[i] == 0)) begin
                    m_code[i] = m_sh[i];
                    m_pend[i] = 0;
                end
                if (md_take && int'(cfg_ch) == i) begin
                    m_sh[i]   = int'(cfg_code);
                    m_pend[i] = 1;
                end
            end
`ifdef DCO_FREQ_MEAS_EN
            if (m_win == WIN - 1) begin
                m_mcount = m_wcnt + md_sel_w;
                m_mvalid = 1;
                m_wcnt   = 0;
                m_win    = 0;
            end else begin
                m_wcnt   = m_wcnt + md_sel_w;
                m_win    = m_win + 1;
                m_mvalid = 0;
            end
`endif
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int exp_ready();
        return (int'(cfg_ch) < CH) ? ((m_pend[cfg_ch] == 0) ? 1 : 0) : 1;
    endfunction

    // Scoreboard compare: every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < CH; i++) begin
                cmp("dco_out", 32'(dco_out[i]), 32'(m_dco[i]));
                cmp("wrap_pulse", 32'(wrap_pulse[i]), 32'(m_wrap[i]));
            end
            cmp("cfg_ready", 32'(cfg_ready), 32'(exp_ready()));
            cmp("meas_count", 32'(meas_count), 32'(m_mcount));
            cmp("meas_valid", 32'(meas_valid), 32'(m_mvalid));
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_wrap(input int ch, input int budget, output int cyc, output int hi);
        cyc = 0;
        hi  = 0;
        do begin
            tick();
            cyc++;
            if (dco_out[ch]) hi++;
        end while (!wrap_pulse[ch] && cyc < budget);
        if (!wrap_pulse[ch]) cmp("wrap_timeout", 32'(cyc), 32'(budget + 1));
    endtask

    task automatic wait_mv(input int budget, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!meas_valid && cyc < budget);
        if (!meas_valid) cmp("meas_timeout", 32'(cyc), 32'(budget + 1));
    endtask

    task automatic write_cfg(input int ch, input int code, input int budget, output int waited);
        logic r;
        r = 1'b0;
        waited = 0;
        cfg_valid = 1'b1;
        cfg_ch    = IW'(ch);
        cfg_code  = CODE_W'(code);
        while (!r && waited < budget) begin
            #1 r = cfg_ready;
            tick();
            waited++;
        end
        cfg_valid = 1'b0;
        if (!r) cmp("cfg_timeout", 32'(waited), 32'(budget + 1));
    endtask

    int c, h, w, n_wrap, n_chg, lvl, n_mv;

    initial begin
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        ena = 1'b1;
        repeat (3) tick();
        cmp("rst_dco", 32'(dco_out), 32'd0);
        cmp("rst_wrap", 32'(wrap_pulse), 32'd0);
        cmp("rst_ready", 32'(cfg_ready), 32'd1);
        cmp("rst_mvalid", 32'(meas_valid), 32'd0);
        cmp("rst_mcount", 32'(meas_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Code 1 on both channels: 256-cycle period, half low half high.
        ch_en = '1;
        wait_wrap(0, 400, c, h);
        cmp("first_wrap_code1", 32'(c), 32'd256);
        wait_wrap(0, 400, c, h);
        cmp("period_code1", 32'(c), 32'd256);
        cmp("high_code1", 32'(h), 32'd128);

        // Code 64 to ch1: busy until its next wrap; ch0 still writable meanwhile.
        write_cfg(1, 64, 4, w);
        cmp("ch1_accept", 32'(w), 32'd1);
        cfg_ch = 1'b1;
        #1 cmp("ch1_busy", 32'(cfg_ready), 32'd0);
        cfg_ch = 1'b0;
        #1 cmp("ch0_free", 32'(cfg_ready), 32'd1);
        write_cfg(0, 2, 4, w);
        cmp("ch0_accept", 32'(w), 32'd1);
        wait_wrap(1, 300, c, h);
        cfg_ch = 1'b1;
        #1 cmp("ch1_free_after_wrap", 32'(cfg_ready), 32'd1);
        wait_wrap(1, 20, c, h);
        cmp("period_code64", 32'(c), 32'd4);

        // Code 0 freezes ch1; then code 32 applies next cycle, period 8.
        write_cfg(1, 0, 10, w);
        repeat (8) tick();
        n_wrap = 0; n_chg = 0; lvl = int'(dco_out[1]);
        repeat (40) begin
            tick();
            if (wrap_pulse[1]) n_wrap++;
            if (int'(dco_out[1]) != lvl) n_chg++;
        end
        cmp("code0_wraps", 32'(n_wrap), 32'd0);
        cmp("code0_level", 32'(n_chg), 32'd0);
        write_cfg(1, 32, 4, w);
        wait_wrap(1, 20, c, h);
        cmp("code32_first", 32'(c), 32'd9);
        wait_wrap(1, 20, c, h);
        cmp("period_code32", 32'(c), 32'd8);

        // Stop ch0 mid-period, restart from zero phase with code 2.
        repeat (37) tick();
        ch_en[0] = 1'b0;
        tick();
        cmp("ch0_off_dco", 32'(dco_out[0]), 32'd0);
        cmp("ch0_off_wrap", 32'(wrap_pulse[0]), 32'd0);
        ch_en[0] = 1'b1;
        wait_wrap(0, 300, c, h);
        cmp("reenable_wrap", 32'(c), 32'd128);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            ena = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 29) == 0) ch_en[$urandom_range(0, CH - 1)] ^= 1'b1;
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = IW'($urandom_range(0, (1 << IW) - 1));
            cfg_code  = ($urandom_range(0, 3) == 0) ? '0 : CODE_W'($urandom_range(1, 255));
            if ($urandom_range(0, 99) == 0) meas_sel = IW'($urandom_range(0, (1 << IW) - 1));
            tick();
        end

        // Measurement: ch0 code 16 gives 1024/16 wraps per window.
        ena = 1'b1; ch_en = '1; cfg_valid = 1'b0; meas_sel = '0;
        write_cfg(0, 16, 600, w);
        wait_wrap(0, 600, c, h);
        wait_wrap(0, 600, c, h);
`ifdef DCO_FREQ_MEAS_EN
        wait_mv(1100, c);
        wait_mv(1100, c);
        cmp("meas_period", 32'(c), 32'(WIN));
        cmp("meas_count_16", 32'(meas_count), 32'd64);
`else
        n_mv = 0;
        repeat (1100) begin
            tick();
            if (meas_valid) n_mv++;
        end
        cmp("meas_valid_off", 32'(n_mv), 32'd0);
        cmp("meas_count_off", 32'(meas_count), 32'd0);
`endif

        // Reset mid-run with channels toggling.
        cfg_ch = '0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        cmp("midrst_dco", 32'(dco_out), 32'd0);
        cmp("midrst_wrap", 32'(wrap_pulse), 32'd0);
        cmp("midrst_mvalid", 32'(meas_valid), 32'd0);
        cmp("midrst_ready", 32'(cfg_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (10) tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
